vgpr_wr_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 64-page VGPR file, which has one write port. It arbitrates between the SIMD ALU writeback (single-beat writes) and the LSU writeback (multi-dword load bursts of 1–4 beats to consecutive VGPR addresses). It drives the VGPR file's write port: 10-bit address, 64-lane page enable, 4-bit sub-word enable and 2048-bit data. Read ports are not touched.

---
 rtl/vgpr_pkg.sv | 20 ++
 rtl/vgpr_wr_rr_arb.sv | 32 +++
 rtl/vgpr_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_vgpr_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgpr_pkg.sv
// Shared types and widths for the VGPR write-port path.
// Imported by the arbiter, its grant sub-module and the bench.
package vgpr_pkg;

  localparam int VGPR_ADDR_W = 10;
  localparam int VGPR_LANES  = 64;
  localparam int VGPR_DATA_W = 2048;
  localparam int VGPR_XOUT_W = 4;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  typedef enum logic {
    REQ_ALU,
    REQ_LSU
  } req_id_e;

endpackage

// File: rtl/vgpr_wr_rr_arb.sv
// Two-way round-robin grant between ALU and LSU writers.
// last_grant only moves when a transaction completes.
import vgpr_pkg::*;

module vgpr_wr_rr_arb (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_alu,
  input  logic    req_lsu,
  input  logic    upd,
  input  req_id_e upd_id,
  output logic    gnt_alu,
  output logic    gnt_lsu
);

  req_id_e last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_LSU;
    end else if (upd) begin
      last_grant <= upd_id;
    end
  end

  // On a tie the side that did not win last time goes first.
  assign gnt_alu = req_alu &
                   (!req_lsu || last_grant == REQ_LSU);
  assign gnt_lsu = req_lsu &
                   (!req_alu || last_grant == REQ_ALU);

endmodule

// File: rtl/vgpr_wr_arbiter.sv
// VGPR write-port arbiter: ALU single beats vs LSU load bursts,
// with a registered write stage feeding the VGPR file.
import vgpr_pkg::*;

module vgpr_wr_arbiter #(
  parameter int NDW_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_wr_valid,
  output logic                   alu_wr_ready,
  input  logic [VGPR_ADDR_W-1:0] alu_wr_addr,
  input  logic [VGPR_LANES-1:0]  alu_wr_mask,
  input  logic [VGPR_XOUT_W-1:0] alu_wr_xoutof4,
  input  logic [VGPR_DATA_W-1:0] alu_wr_data,
  input  logic                   lsu_wr_valid,
  output logic                   lsu_wr_ready,
  input  logic [VGPR_ADDR_W-1:0] lsu_wr_addr,
  input  logic [NDW_W-1:0]       lsu_wr_ndw,
  input  logic [VGPR_LANES-1:0]  lsu_wr_mask,
  input  logic [VGPR_XOUT_W-1:0] lsu_wr_xoutof4,
  input  logic [VGPR_DATA_W-1:0] lsu_wr_data,
  output logic [VGPR_ADDR_W-1:0] wr0_addr,
  output logic [VGPR_LANES-1:0]  wr0_en,
  output logic [VGPR_XOUT_W-1:0] wr0_en_xoutof4,
  output logic [VGPR_DATA_W-1:0] wr0_data,
  output logic                   busy
);

  state_e                 state;
  logic [VGPR_ADDR_W-1:0] base;
  logic [NDW_W-1:0]       rem;
  logic [NDW_W-1:0]       beat;

  logic    idle;
  logic    gnt_alu;
  logic    gnt_lsu;
  logic    alu_acc;
  logic    lsu_first;
  logic    lsu_beat;
  logic    lsu_last;
  logic    upd;
  req_id_e upd_id;

  assign idle = (state == IDLE);

  vgpr_wr_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (alu_wr_valid & idle),
    .req_lsu (lsu_wr_valid & idle),
    .upd     (upd),
    .upd_id  (upd_id),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  assign alu_acc   = gnt_alu;
  assign lsu_first = gnt_lsu;
  assign lsu_beat  = !idle & lsu_wr_valid;
  assign lsu_last  = (lsu_first & (lsu_wr_ndw == '0)) |
                     (lsu_beat & (beat == rem));

  assign alu_wr_ready = alu_acc;
  assign lsu_wr_ready = lsu_first | lsu_beat;

  assign upd    = alu_acc | lsu_last;
  assign upd_id = alu_acc ? REQ_ALU : REQ_LSU;

  assign busy = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      rem   <= '0;
      beat  <= '0;
    end else if (lsu_first) begin
      base  <= lsu_wr_addr;
      rem   <= lsu_wr_ndw;
      beat  <= NDW_W'(1);
      state <= (lsu_wr_ndw == '0) ? IDLE : BURST;
    end else if (lsu_beat) begin
      if (beat == rem) begin
        state <= IDLE;
      end else begin
        beat <= beat + NDW_W'(1);
      end
    end
  end

  // Address and data hold on idle cycles; only the enables drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_addr       <= '0;
      wr0_en         <= '0;
      wr0_en_xoutof4 <= '0;
      wr0_data       <= '0;
    end else begin
      unique case (1'b1)
        alu_acc: begin
          wr0_addr       <= alu_wr_addr;
          wr0_en         <= alu_wr_mask;
          wr0_en_xoutof4 <= alu_wr_xoutof4;
          wr0_data       <= alu_wr_data;
        end
        lsu_first: begin
          wr0_addr       <= lsu_wr_addr;
          wr0_en         <= lsu_wr_mask;
          wr0_en_xoutof4 <= lsu_wr_xoutof4;
          wr0_data       <= lsu_wr_data;
        end
        lsu_beat: begin
          wr0_addr       <= base + VGPR_ADDR_W'(beat);
          wr0_en         <= lsu_wr_mask;
          wr0_en_xoutof4 <= lsu_wr_xoutof4;
          wr0_data       <= lsu_wr_data;
        end
        default: begin
          wr0_en         <= '0;
          wr0_en_xoutof4 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vgpr_wr_arbiter.sv
// Bench for vgpr_wr_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
import vgpr_pkg::*;

module tb_vgpr_wr_arbiter;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         alu_v = 0;
  logic         alu_r;
  logic [9:0]   alu_a = '0;
  logic [63:0]  alu_m = '0;
  logic [3:0]   alu_x = '0;
  logic [2047:0] alu_d = '0;
  logic         lsu_v = 0;
  logic         lsu_r;
  logic [9:0]   lsu_a = '0;
  logic [1:0]   lsu_n = '0;
  logic [63:0]  lsu_m = '0;
  logic [3:0]   lsu_x = '0;
  logic [2047:0] lsu_d = '0;
  logic [9:0]   wr0_addr;
  logic [63:0]  wr0_en;
  logic [3:0]   wr0_x;
  logic [2047:0] wr0_data;
  logic         busy;

  always #5 clk = ~clk;

  vgpr_wr_arbiter #(.NDW_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_wr_valid   (alu_v),
    .alu_wr_ready   (alu_r),
    .alu_wr_addr    (alu_a),
    .alu_wr_mask    (alu_m),
    .alu_wr_xoutof4 (alu_x),
    .alu_wr_data    (alu_d),
    .lsu_wr_valid   (lsu_v),
    .lsu_wr_ready   (lsu_r),
    .lsu_wr_addr    (lsu_a),
    .lsu_wr_ndw     (lsu_n),
    .lsu_wr_mask    (lsu_m),
    .lsu_wr_xoutof4 (lsu_x),
    .lsu_wr_data    (lsu_d),
    .wr0_addr       (wr0_addr),
    .wr0_en         (wr0_en),
    .wr0_en_xoutof4 (wr0_x),
    .wr0_data       (wr0_data),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: beats still owed by the current burst, next burst
  // address, and who completed the last transaction.
  int  m_left;
  int  m_next;
  bit  m_last_alu;

  logic [9:0]    e_addr;
  logic [63:0]   e_en;
  logic [3:0]    e_x;
  logic [2047:0] e_data;
  bit            e_busy;
  bit            g_alu_acc;
  bit            g_lsu_acc;

  int trace[$];
  int busy_cnt;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left     = 0;
    m_next     = 0;
    m_last_alu = 0;
    e_addr     = '0;
    e_en       = '0;
    e_x        = '0;
    e_data     = '0;
    e_busy     = 0;
  endtask

  task automatic step();
    bit ar;
    bit lr;
    @(negedge clk);
    if (m_left > 0) begin
      ar = 0;
      lr = lsu_v;
    end else begin
      ar = alu_v && (!lsu_v || !m_last_alu);
      lr = lsu_v && (!alu_v || m_last_alu);
    end
    chk("alu_ready", {63'b0, alu_r}, {63'b0, ar});
    chk("lsu_ready", {63'b0, lsu_r}, {63'b0, lr});
    g_alu_acc = ar;
    g_lsu_acc = lr;
    if (ar) begin
      e_addr = alu_a; e_en = alu_m; e_x = alu_x; e_data = alu_d;
      m_last_alu = 1;
    end else if (lr && m_left > 0) begin
      e_addr = 10'(m_next); e_en = lsu_m; e_x = lsu_x; e_data = lsu_d;
      m_next = (m_next + 1) % 1024;
      m_left--;
      if (m_left == 0) m_last_alu = 0;
    end else if (lr) begin
      e_addr = lsu_a; e_en = lsu_m; e_x = lsu_x; e_data = lsu_d;
      m_left = int'(lsu_n);
      m_next = (int'(lsu_a) + 1) % 1024;
      if (m_left == 0) m_last_alu = 0;
    end else begin
      e_en = '0;
      e_x  = '0;
    end
    e_busy = (m_left > 0);
    @(posedge clk);
    #1;
    chk("wr0_en", wr0_en, e_en);
    chk("wr0_xoutof4", {60'b0, wr0_x}, {60'b0, e_x});
    chk("wr0_addr", {54'b0, wr0_addr}, {54'b0, e_addr});
    chk("wr0_data", {63'b0, wr0_data === e_data}, 64'd1);
    chk("busy", {63'b0, busy}, {63'b0, e_busy});
    trace.push_back((wr0_en != '0) ? int'(wr0_addr) : -1);
    if (busy) busy_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 0;
    alu_v = 0;
    lsu_v = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", wr0_en, 64'd0);
    chk("rst_x", {60'b0, wr0_x}, 64'd0);
    chk("rst_addr", {54'b0, wr0_addr}, 64'd0);
    chk("rst_data", {63'b0, wr0_data === '0}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    rst_n = 1;
  endtask

  task automatic chk_trace(string nm, int n, int e[8]);
    chk({nm, "_len"}, 64'(trace.size()), 64'(n));
    for (int i = 0; i < n && i < trace.size(); i++)
      chk(nm, 64'(trace[i]), 64'(e[i]));
  endtask

  task automatic rnd_alu();
    alu_a = 10'($urandom);
    alu_m = ($urandom_range(0, 7) == 0) ? 64'd0 :
            {$urandom, $urandom};
    alu_x = 4'($urandom);
    for (int i = 0; i < 64; i++) alu_d[i*32 +: 32] = $urandom;
  endtask

  task automatic rnd_lsu();
    lsu_a = 10'($urandom);
    lsu_n = 2'($urandom);
    lsu_m = ($urandom_range(0, 7) == 0) ? 64'd0 :
            {$urandom, $urandom};
    lsu_x = 4'($urandom);
    for (int i = 0; i < 64; i++) lsu_d[i*32 +: 32] = $urandom;
  endtask

  initial begin
    model_reset();
    busy_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // ALU back-to-back to 5, 6, 7
    trace.delete();
    alu_m = '1;
    alu_x = 4'hF;
    for (int i = 0; i < 3; i++) begin
      alu_v = 1;
      alu_a = 10'(5 + i);
      alu_d = {64{32'(i + 1)}};
      step();
    end
    alu_v = 0;
    chk_trace("alu_seq", 3, '{5, 6, 7, 0, 0, 0, 0, 0});

    // LSU wraps 1022..1 while ALU waits
    trace.delete();
    busy_cnt = 0;
    alu_v = 1; alu_a = 10'd9;
    lsu_v = 1; lsu_a = 10'd1022; lsu_n = 2'd3;
    lsu_m = '1; lsu_x = 4'hF;
    for (int i = 0; i < 4; i++) begin
      lsu_d = {64{32'(100 + i)}};
      step();
    end
    lsu_v = 0;
    step();
    alu_v = 0;
    chk_trace("wrap", 5, '{1022, 1023, 0, 1, 9, 0, 0, 0});
    chk("busy_cycles", 64'(busy_cnt), 64'd3);

    // tie alternation from reset
    do_reset();
    trace.delete();
    alu_v = 1; alu_a = 10'd100;
    lsu_v = 1; lsu_a = 10'd200; lsu_n = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (g_alu_acc) alu_a = alu_a + 10'd1;
      if (g_lsu_acc) lsu_a = lsu_a + 10'd1;
    end
    alu_v = 0;
    lsu_v = 0;
    chk_trace("alternate", 4, '{100, 200, 101, 201, 0, 0, 0, 0});

    // burst with a 2-cycle bubble
    trace.delete();
    lsu_v = 1; lsu_a = 10'd50; lsu_n = 2'd2;
    step();
    lsu_v = 0;
    step();
    step();
    lsu_v = 1;
    step();
    step();
    lsu_v = 0;
    chk_trace("bubble", 5, '{50, -1, -1, 51, 52, 0, 0, 0});

    // partial mask and sub-word enable
    alu_v = 1; alu_a = 10'd33;
    alu_m = 64'h0000_0000_FFFF_0000;
    alu_x = 4'b0101;
    step();
    alu_v = 0;
    chk("part_en", wr0_en, 64'h0000_0000_FFFF_0000);
    chk("part_x", {60'b0, wr0_x}, 64'd5);

    // reset during beat 2 of a 4-beat burst
    do_reset();
    lsu_v = 1; lsu_a = 10'd300; lsu_n = 2'd3;
    lsu_m = '1; lsu_x = 4'hF;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("midrst_en", wr0_en, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    model_reset();
    rst_n = 1;
    trace.delete();
    alu_v = 1; alu_a = 10'd400; alu_m = '1;
    lsu_v = 1; lsu_a = 10'd500; lsu_n = 2'd0;
    step();
    alu_v = 0;
    step();
    lsu_v = 0;
    chk_trace("after_rst", 2, '{400, 500, 0, 0, 0, 0, 0, 0});

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!alu_v || g_alu_acc) begin
        alu_v = ($urandom_range(0, 2) != 0);
        rnd_alu();
      end
      if (!lsu_v || g_lsu_acc) begin
        lsu_v = ($urandom_range(0, 2) != 0);
        rnd_lsu();
      end
      g_alu_acc = 0;
      g_lsu_acc = 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
